// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the memory port arbiter
// Read-return ownership encoding and default bus widths.
package mem_arb_pkg;

  localparam int ADDR_W_DEF   = 16;
  localparam int DATA_W_DEF   = 16;
  localparam int STARVE_CNT_W = 4;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_LDST  = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch, load/store and memory signals of the arbiter
// slave is the arbiter's view; master is the cpu/memory side that drives requests and read data.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic [ADDR_W-1:0] i_pc_addr;
  logic              i_pc_rd;
  logic              o_pc_waitreq;
  logic              o_pc_rdvalid;
  logic [DATA_W-1:0] o_pc_rddata;

  logic [ADDR_W-1:0] i_ldst_addr;
  logic              i_ldst_rd;
  logic              i_ldst_wr;
  logic [DATA_W-1:0] i_ldst_wrdata;
  logic              o_ldst_waitreq;
  logic              o_ldst_rdvalid;
  logic [DATA_W-1:0] o_ldst_rddata;

  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_rd;
  logic              o_mem_wr;
  logic [DATA_W-1:0] o_mem_wrdata;
  logic [DATA_W-1:0] i_mem_rddata;

  logic              o_err;

  modport slave (
    input  i_pc_addr, i_pc_rd,
    output o_pc_waitreq, o_pc_rdvalid, o_pc_rddata,
    input  i_ldst_addr, i_ldst_rd, i_ldst_wr, i_ldst_wrdata,
    output o_ldst_waitreq, o_ldst_rdvalid, o_ldst_rddata,
    output o_mem_addr, o_mem_rd, o_mem_wr, o_mem_wrdata,
    input  i_mem_rddata,
    output o_err
  );

  modport master (
    output i_pc_addr, i_pc_rd,
    input  o_pc_waitreq, o_pc_rdvalid, o_pc_rddata,
    output i_ldst_addr, i_ldst_rd, i_ldst_wr, i_ldst_wrdata,
    input  o_ldst_waitreq, o_ldst_rdvalid, o_ldst_rddata,
    input  o_mem_addr, o_mem_rd, o_mem_wr, o_mem_wrdata,
    output i_mem_rddata,
    input  o_err
  );

endinterface

// File: rtl/mem_port_arbiter_starve_ctr.sv
// rtl/mem_port_arbiter_starve_ctr.sv - saturating count of consecutive denied fetch cycles
// at_limit tells the arbiter that fetch must win this cycle.
module arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int W = STARVE_CNT_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         at_limit
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != limit)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == limit);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one single-port memory between fetch and load/store
// Load/store has priority unless fetch has been starved for STARVE_LIMIT cycles.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input logic             clk,
  input logic             reset,
  mem_port_arbiter_if.slave bus
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic pc_req;
  logic ldst_req;
  logic ldst_is_wr;
  logic at_limit;
  logic fetch_wins;
  logic gnt_pc;
  logic gnt_ldst;

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wrdata_q;
  logic [DATA_W-1:0] wrdata_d;
  owner_t            owner_q;
  owner_t            owner_d;
  logic              err_q;
  logic              err_d;

  assign pc_req     = bus.i_pc_rd;
  assign ldst_req   = bus.i_ldst_rd | bus.i_ldst_wr;
  // rd and wr together is resolved as a write
  assign ldst_is_wr = bus.i_ldst_wr;

  assign fetch_wins = pc_req & (at_limit | ~ldst_req);
  assign gnt_pc     = ~reset & fetch_wins;
  assign gnt_ldst   = ~reset & ldst_req & ~fetch_wins;

  arb_starve_ctr #(
    .W (STARVE_CNT_W)
  ) u_starve_ctr (
    .clk      (clk),
    .reset    (reset),
    .inc      (pc_req & ~gnt_pc),
    .clr      (~pc_req | gnt_pc),
    .limit    (LIMIT),
    .at_limit (at_limit)
  );

  always_comb begin
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
    owner_d  = OWN_NONE;
    if (gnt_pc) begin
      addr_d  = bus.i_pc_addr;
      owner_d = OWN_FETCH;
    end else if (gnt_ldst) begin
      addr_d = bus.i_ldst_addr;
      if (ldst_is_wr) begin
        wrdata_d = bus.i_ldst_wrdata;
      end else begin
        owner_d = OWN_LDST;
      end
    end
  end

  assign err_d = err_q | (bus.i_ldst_rd & bus.i_ldst_wr);

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      wrdata_q <= '0;
      owner_q  <= OWN_NONE;
      err_q    <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      owner_q  <= owner_d;
      err_q    <= err_d;
    end
  end

  // Idle cycles keep presenting the last address/data to the memory
  assign bus.o_mem_addr   = addr_d;
  assign bus.o_mem_wrdata = wrdata_d;
  assign bus.o_mem_rd     = gnt_pc | (gnt_ldst & ~ldst_is_wr);
  assign bus.o_mem_wr     = gnt_ldst & ldst_is_wr;

  assign bus.o_pc_waitreq   = reset | (pc_req & ~gnt_pc);
  assign bus.o_ldst_waitreq = reset | (ldst_req & ~gnt_ldst);

  // Gating with reset drops a read that was granted just before reset
  assign bus.o_pc_rdvalid   = ~reset & (owner_q == OWN_FETCH);
  assign bus.o_ldst_rdvalid = ~reset & (owner_q == OWN_LDST);
  assign bus.o_pc_rddata    = bus.i_mem_rddata;
  assign bus.o_ldst_rddata  = bus.i_mem_rddata;

  assign bus.o_err = err_q;

endmodule
